// File: rtl/teclado_barrido_if.sv
// Keypad pin bundle: column inputs from the matrix, row drive and decoded key outputs.
interface teclado_barrido_if;
  logic [3:0] columnas;
  logic [3:0] filas;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       tecla_presionada;

  // Scan controller side
  modport master (
    input  columnas,
    output filas,
    output tecla,
    output tecla_valida,
    output tecla_presionada
  );

  // Keypad / key consumer side
  modport slave (
    output columnas,
    input  filas,
    input  tecla,
    input  tecla_valida,
    input  tecla_presionada
  );
endinterface

// File: rtl/teclado_barrido.sv
// 4x4 matrix keypad scanner: drives one row low at a time, synchronizes the
// columns, debounces press and release on divider ticks and emits a key code
// with a single-cycle valid strobe.
module teclado_barrido #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  teclado_barrido_if.master bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  logic [3:0]       col_m;
  logic [3:0]       col_s;
  logic [DIV_W-1:0] div_q;
  logic             tick;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       filas_q, filas_d;
  logic [3:0]       col_lat_q, col_lat_d;
  logic [3:0]       tecla_q, tecla_d;
  logic             valida_q, valida_d;

  // True when exactly one column line is pulled low.
  function automatic logic one_low(input logic [3:0] c);
    case (c)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  // Next row in the scan sequence 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [3:0] next_row(input logic [3:0] f);
    next_row = {f[2:0], f[3]};
  endfunction

  // Key code for the active-low row drive and single-low column pattern.
  function automatic logic [3:0] key_code(input logic [3:0] f, input logic [3:0] c);
    key_code = 4'h0;
    case (f)
      4'b0111: begin
        case (c)
          4'b0111: key_code = 4'h1;
          4'b1011: key_code = 4'h2;
          4'b1101: key_code = 4'h3;
          default: key_code = 4'hA;
        endcase
      end
      4'b1011: begin
        case (c)
          4'b0111: key_code = 4'h4;
          4'b1011: key_code = 4'h5;
          4'b1101: key_code = 4'h6;
          default: key_code = 4'hB;
        endcase
      end
      4'b1101: begin
        case (c)
          4'b0111: key_code = 4'h7;
          4'b1011: key_code = 4'h8;
          4'b1101: key_code = 4'h9;
          default: key_code = 4'hC;
        endcase
      end
      default: begin
        case (c)
          4'b0111: key_code = 4'hE;
          4'b1011: key_code = 4'h0;
          4'b1101: key_code = 4'hF;
          default: key_code = 4'hD;
        endcase
      end
    endcase
  endfunction

  // Two-stage synchronizer for the asynchronous column lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= '1;
      col_s <= '1;
    end else begin
      col_m <= bus.columnas;
      col_s <= col_m;
    end
  end

  // Row-step divider; tick marks the last cycle of each period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick    = (div_q == DIV_LAST);
  assign cnt_inc = cnt_q + CNT_ONE;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      filas_q   <= 4'b1110;
      col_lat_q <= '1;
      tecla_q   <= '0;
      valida_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      filas_q   <= filas_d;
      col_lat_q <= col_lat_d;
      tecla_q   <= tecla_d;
      valida_q  <= valida_d;
    end
  end

  // Scan/debounce decisions, evaluated only on divider ticks.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    filas_d   = filas_q;
    col_lat_d = col_lat_q;
    tecla_d   = tecla_q;
    valida_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (one_low(col_s)) begin
            col_lat_d = col_s;
            cnt_d     = CNT_ONE;
            state_d   = DEBOUNCE;
          end else begin
            filas_d = next_row(filas_q);
          end
        end
        DEBOUNCE: begin
          if (col_s == col_lat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_d  = PRESSED;
              tecla_d  = key_code(filas_q, col_lat_q);
              valida_d = 1'b1;
            end
          end else begin
            state_d = SCAN;
            filas_d = next_row(filas_q);
          end
        end
        PRESSED: begin
          if (col_s == 4'hF) begin
            state_d = RELEASE;
            cnt_d   = CNT_ONE;
          end
        end
        RELEASE: begin
          if (col_s == 4'hF) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_d = SCAN;
              filas_d = next_row(filas_q);
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign bus.filas            = filas_q;
  assign bus.tecla            = tecla_q;
  assign bus.tecla_valida     = valida_q;
  assign bus.tecla_presionada = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: tb/tb_teclado_barrido.sv
// Randomized bench for teclado_barrido with a per-cycle behavioural reference
// model and directed keypad scenarios.
module tb_teclado_barrido;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE_N = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] keys;       // bit r*4+c: key at row bit r, column bit c held down
  logic [3:0]  colv;
  logic [63:0] keymap = 64'h123A_456B_789C_E0FD;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  teclado_barrido_if kb ();

  teclado_barrido #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_N(DEBOUNCE_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad: a held key pulls its column low only while its row is driven.
  always_comb begin
    colv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kb.filas[r]) colv[c] = 1'b0;
  end
  assign kb.columnas = colv;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] code_of(input int r, input int c);
    return keymap[(r*4+c)*4 +: 4];
  endfunction

  function automatic logic [3:0] row_drive(input int r);
    logic [3:0] one = 4'b0001;
    return ~(one << r);
  endfunction

  // ---------------- reference model ----------------
  int         m_div, m_row, m_run, m_rel;
  logic [3:0] m_s1, m_s2, m_cand, m_tecla;
  bit         m_pressed, m_valida;

  task automatic model_reset();
    m_div = 0; m_row = 0; m_run = 0; m_rel = 0;
    m_s1 = 4'hF; m_s2 = 4'hF; m_cand = 4'hF; m_tecla = 4'h0;
    m_pressed = 0; m_valida = 0;
  endtask

  // Advance the model by one clock using the column value about to be sampled.
  task automatic model_step(input logic [3:0] col_in);
    bit         tk;
    logic [3:0] cs;
    int         lows, lowcol;
    tk = (m_div == SCAN_DIV - 1);
    cs = m_s2;
    m_s2 = m_s1;
    m_s1 = col_in;
    m_div = (m_div + 1) % SCAN_DIV;
    m_valida = 0;
    if (!tk) return;
    lows = 0; lowcol = 0;
    for (int c = 0; c < 4; c++) if (!cs[c]) begin lows++; lowcol = c; end
    if (!m_pressed) begin
      if (m_run == 0) begin
        if (lows == 1) begin m_cand = cs; m_run = 1; end
        else m_row = (m_row + 1) % 4;
      end else if (cs == m_cand) begin
        m_run++;
        if (m_run == DEBOUNCE_N) begin
          m_pressed = 1; m_run = 0; m_rel = 0; m_valida = 1;
          m_tecla = code_of(m_row, lowcol);
        end
      end else begin
        m_run = 0;
        m_row = (m_row + 1) % 4;
      end
    end else begin
      if (cs == 4'hF) begin
        m_rel++;
        if (m_rel == DEBOUNCE_N) begin
          m_pressed = 0; m_rel = 0;
          m_row = (m_row + 1) % 4;
        end
      end else begin
        m_rel = 0;
      end
    end
  endtask

  // Compare every output against the model each cycle, then step the model.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    check_val("filas", kb.filas, row_drive(m_row));
    check_val("tecla", kb.tecla, m_tecla);
    check_val("tecla_valida", kb.tecla_valida, m_valida);
    check_val("tecla_presionada", kb.tecla_presionada, m_pressed);
    if (kb.tecla_valida) pulses++;
    if (rst_n) model_step(kb.columnas);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_row(input int r);
    bit ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (kb.filas == row_drive(r)) begin ok = 1; break; end
      step(1);
    end
    if (!ok) check_val("row_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_level(input logic lvl, input string tag);
    bit ok = 0;
    for (int i = 0; i < 150; i++) begin
      if (kb.tecla_presionada == lvl) begin ok = 1; break; end
      step(1);
    end
    if (!ok) check_val(tag, 32'd0, 32'd1);
  endtask

  task automatic key_cycle(input int r, input int c);
    int start = pulses;
    wait_row(r);
    keys[r*4+c] = 1'b1;
    wait_level(1'b1, "press_timeout");
    step($urandom_range(2, 12));
    keys = '0;
    wait_level(1'b0, "release_timeout");
    step(2);
    check_val("pulse_count", pulses - start, 32'd1);
    check_val("tecla_code", kb.tecla, code_of(r, c));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    keys  = '0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;

    // 1: idle scan, no key
    check_val("reset_tecla", kb.tecla, 32'h0);
    check_val("reset_filas", kb.filas, 32'hE);
    step(40);
    check_val("idle_pulses", pulses, 32'd0);

    // 2: key 7 held; scan must stop on its row
    start = pulses;
    wait_row(1);
    keys[1*4+3] = 1'b1;
    wait_level(1'b1, "press7_timeout");
    step(12);
    check_val("held_filas", kb.filas, 32'hD);
    check_val("held_tecla", kb.tecla, 32'h7);
    keys = '0;
    wait_level(1'b0, "release7_timeout");
    check_val("key7_pulses", pulses - start, 32'd1);
    step(20);

    // 3: keys 8, 9, C
    key_cycle(1, 2);
    key_cycle(1, 1);
    key_cycle(1, 0);

    // 4: key # with a bounce during debounce
    start = pulses;
    wait_row(0);
    keys[0*4+1] = 1'b1;
    step(7);
    keys = '0;
    step(4);
    keys[0*4+1] = 1'b1;
    wait_level(1'b1, "bounce_timeout");
    step(3);
    check_val("bounce_pulses", pulses - start, 32'd1);
    check_val("bounce_tecla", kb.tecla, 32'hF);
    keys = '0;
    wait_level(1'b0, "bounce_rel_timeout");

    // 5: key 5 with a short release glitch
    start = pulses;
    wait_row(2);
    keys[2*4+2] = 1'b1;
    wait_level(1'b1, "key5_timeout");
    step(5);
    keys = '0;
    step(6);
    keys[2*4+2] = 1'b1;
    step(8);
    check_val("glitch_held", kb.tecla_presionada, 32'd1);
    keys = '0;
    wait_level(1'b0, "key5_rel_timeout");
    check_val("glitch_pulses", pulses - start, 32'd1);
    check_val("glitch_tecla", kb.tecla, 32'h5);

    // 6: multi-key on one row, then reset in the middle of a debounce
    start = pulses;
    keys[0*4+3] = 1'b1;
    keys[0*4+2] = 1'b1;
    step(40);
    check_val("multi_pulses", pulses - start, 32'd0);
    check_val("multi_held", kb.tecla_presionada, 32'd0);
    keys = '0;
    wait_row(0);
    keys[0*4+0] = 1'b1;
    step(6);
    rst_n = 1'b0;
    step(1);
    check_val("rst_filas", kb.filas, 32'hE);
    check_val("rst_tecla", kb.tecla, 32'h0);
    check_val("rst_valida", kb.tecla_valida, 32'd0);
    check_val("rst_held", kb.tecla_presionada, 32'd0);
    keys = '0;
    step(2);
    rst_n = 1'b1;
    start = pulses;
    step(30);
    check_val("post_rst_pulses", pulses - start, 32'd0);
    key_cycle(0, 0);

    // Random presses, holds, releases and occasional second keys
    for (int i = 0; i < 16; i++) begin
      keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      step($urandom_range(1, 40));
      keys = '0;
      step($urandom_range(1, 30));
    end
    step(40);
    for (int i = 0; i < 4; i++) key_cycle($urandom_range(0, 3), $urandom_range(0, 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/teclado_barrido.md
Name: teclado_barrido

Overview:
Scan controller for the 4x4 matrix keypad. It drives the row lines (filas) one at a time, samples the column lines (columnas), debounces press and release, and outputs a 4-bit key code with a one-cycle valid strobe. It sits between the keypad pins and the downstream key consumers (display/entry logic), and it sequences the row/column decode that the teclado block performs combinationally.

Parameters:
SCAN_DIV, 1000, clk cycles per row step; one "tick" every SCAN_DIV cycles (minimum 4).
DEBOUNCE_N, 4, consecutive matching ticks required to accept a press or a release (minimum 2).

Ports:
clk  input  1  system clock.
rst_n  input  1  reset, asynchronous, active-low.
columnas  input  4  raw keypad columns, active-low, asynchronous to clk; bit3 = leftmost column.
filas  output  4  row drive, active-low, exactly one bit low at all times.
tecla  output  4  last accepted key code.
tecla_valida  output  1  one-cycle pulse when a new key is accepted.
tecla_presionada  output  1  high while the accepted key is held (PRESSED and RELEASE states).

Behaviour:
- Reset (async, rst_n=0): filas=4'b1110, tecla=4'h0, tecla_valida=0, tecla_presionada=0, state=SCAN, divider=0, debounce count=0, synchronizer regs=4'b1111.
- columnas passes through a 2-FF synchronizer (col_s). Only col_s is used; added latency is 2 cycles.
- Divider counts 0..SCAN_DIV-1 and wraps. tick=1 on the cycle the count equals SCAN_DIV-1. All sampling and state decisions occur on tick only.
- Row order: 1110 -> 1101 -> 1011 -> 0111 -> 1110 (wraps). Rows advance only on tick, and only in SCAN.
- Key map (filas low bit / columnas low bit, col bit3..0):
  - filas bit3: 1,2,3,A.
  - filas bit2: 4,5,6,B.
  - filas bit1: 7,8,9,C.
  - filas bit0: *,0,#,D.
  - Codes: digits = value, A=A, B=B, C=C, D=D, *=E, #=F.
- SCAN:
  - tick with exactly one col_s bit low: latch row and column, set cnt=1, go to DEBOUNCE. filas is held.
  - tick with col_s=1111 or with more than one bit low (ghost/multi-key): advance the row and stay in SCAN.
- DEBOUNCE:
  - tick with col_s equal to the latched pattern: increment cnt. When cnt reaches DEBOUNCE_N, go to PRESSED, load tecla, and pulse tecla_valida in the following cycle (aligned with the state change).
  - tick with a mismatch: go to SCAN, advance the row, and do not pulse.
- PRESSED: tecla_presionada=1 and filas is held.
  - tick with col_s=1111: go to RELEASE with cnt=1.
  - Any other pattern: stay in PRESSED. There is no auto-repeat.
- RELEASE: tecla_presionada stays 1.
  - tick with col_s=1111: increment cnt. When cnt reaches DEBOUNCE_N, go to SCAN, advance the row, and set tecla_presionada=0.
  - tick with a non-1111 pattern: return to PRESSED. No new tecla_valida is produced.
- tecla holds its value until the next accepted key. tecla_valida is never high for 2 consecutive cycles.
- Press latency: a stable key produces tecla_valida on the DEBOUNCE_N-th consecutive matching tick after its row is first driven, plus 1 cycle.
- Reset mid-operation: all state returns to reset values immediately. There are no spurious pulses after rst_n deasserts.
- A key on a non-driven row is invisible. A press on the current row between ticks is detected at the next tick.

Test Plan:
(Bench settings: SCAN_DIV=4, DEBOUNCE_N=3. The keypad model pulls the pressed key's column low only while its row's filas bit is low.)
1. Reset then idle, no key -> filas cycles 1110,1101,1011,0111,1110 every 4 clks; tecla_valida stays 0; tecla=0.
2. Hold key 7 (filas bit1, columnas 0111) -> scan stops with filas=1101; exactly one tecla_valida pulse, tecla=4'h7, tecla_presionada=1 until 3 release ticks after letting go, then scanning resumes.
3. Keys 8, 9, C in sequence, each with a full release -> three pulses with tecla=8, 9, C.
4. Key # pressed with a bounce (released for 1 tick during DEBOUNCE) -> no pulse on the bounce; one pulse (tecla=F) after 3 stable ticks.
5. Key 5 held, with a 1-tick release glitch in RELEASE -> returns to PRESSED, no second pulse, tecla stays 5.
6. Two keys in the same row (columnas 0011 on row 1110), then rst_n pulsed low mid-DEBOUNCE on key D -> no pulse for the multi-key; outputs return to reset values immediately; no pulse after reset until a new debounced press.
